// File: rtl/cfg_switch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cfg_switch_ctrl_pkg
// Shared definitions for the configuration-switch sequencer and the kernel
// configurator: default widths, the number of legal dataflow configurations,
// the named configuration IDs and the sequencer state encoding.
// -----------------------------------------------------------------------------
package cfg_switch_ctrl_pkg;

  localparam int CFG_ID_W       = 8;  // configuration ID width (configurator input)
  localparam int CFG_NUM_CFG    = 3;  // legal IDs are 1..CFG_NUM_CFG
  localparam int CFG_CNT_W      = 8;  // in-flight token counter width
  localparam int CFG_SETTLE_CYC = 2;  // cycles the new ID settles before streaming

  // Named configuration IDs, shared with the configurator.
  localparam logic [CFG_ID_W-1:0] CFG_ID_1 = CFG_ID_W'(1);
  localparam logic [CFG_ID_W-1:0] CFG_ID_2 = CFG_ID_W'(2);
  localparam logic [CFG_ID_W-1:0] CFG_ID_3 = CFG_ID_W'(3);

  // Sequencer states.
  typedef enum logic [1:0] {
    CFG_UNCFG  = 2'd0,  // no configuration loaded since reset
    CFG_ACTIVE = 2'd1,  // configured, streaming allowed
    CFG_DRAIN  = 2'd2,  // waiting for the network to empty
    CFG_SETTLE = 2'd3   // new ID driven, waiting for it to settle
  } cfg_state_e;

endpackage : cfg_switch_ctrl_pkg

// File: rtl/cfg_switch_ctrl_if.sv
// -----------------------------------------------------------------------------
// cfg_switch_ctrl_if
// Valid/ready request channel carrying a configuration ID from the HWPE
// control slave (master side) into the sequencer (slave side).
//   valid : request valid
//   id    : requested configuration ID
//   ready : sequencer can take a request this cycle
// -----------------------------------------------------------------------------
interface cfg_switch_ctrl_if
  import cfg_switch_ctrl_pkg::*;
#(
  parameter int ID_W = CFG_ID_W
);

  logic            valid;
  logic [ID_W-1:0] id;
  logic            ready;

  modport master (output valid, output id, input  ready);
  modport slave  (input  valid, input  id, output ready);

endinterface : cfg_switch_ctrl_if

// File: rtl/cfg_inflight_cnt.sv
// -----------------------------------------------------------------------------
// cfg_inflight_cnt
// Saturating up/down counter of tokens currently inside the reconfigurable
// network.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   inc_i         : a token entered the network this cycle
//   dec_i         : a token left the network this cycle
//   cnt_o         : current in-flight count
//   err_o         : this cycle's update would overflow or underflow (the
//                   count holds instead)
// -----------------------------------------------------------------------------
module cfg_inflight_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             up, dn;

  // Simultaneous entry and exit leave the count unchanged.
  assign up = inc_i & ~dec_i;
  assign dn = dec_i & ~inc_i;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (up) begin
      if (cnt_q == '1) err_o = 1'b1;
      else             cnt_d = cnt_q + CNT_W'(1);
    end else if (dn) begin
      if (cnt_q == '0) err_o = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule : cfg_inflight_cnt

// File: rtl/cfg_switch_ctrl.sv
// -----------------------------------------------------------------------------
// cfg_switch_ctrl
// Upstream sequencer for the kernel configurator. Takes configuration-ID
// requests, waits until the network holds no in-flight tokens, switches the
// ID, holds it for a settle window and then re-enables streaming.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req           : request channel (slave modport): valid, id, ready
//   in_fire_i     : token entered network this cycle
//   out_fire_i    : token left network this cycle
//   id_o          : ID driven to the configurator
//   cfg_valid_o   : network configured, input streamer may fire
//   busy_o        : reconfiguration in progress (draining or settling)
//   inflight_o    : current in-flight token count
//   bad_id_o      : one-cycle pulse, an accepted request carried an illegal ID
//   proto_err_o   : sticky, counter over/underflow or in_fire_i while not
//                   configured
// -----------------------------------------------------------------------------
module cfg_switch_ctrl
  import cfg_switch_ctrl_pkg::*;
#(
  parameter int ID_W       = CFG_ID_W,
  parameter int NUM_CFG    = CFG_NUM_CFG,
  parameter int CNT_W      = CFG_CNT_W,
  parameter int SETTLE_CYC = CFG_SETTLE_CYC   // must be >= 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  cfg_switch_ctrl_if.slave   req,
  input  logic               in_fire_i,
  input  logic               out_fire_i,
  output logic [ID_W-1:0]    id_o,
  output logic               cfg_valid_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   inflight_o,
  output logic               bad_id_o,
  output logic               proto_err_o
);

  localparam logic [1:0] ST_UNCFG  = CFG_UNCFG;
  localparam logic [1:0] ST_ACTIVE = CFG_ACTIVE;
  localparam logic [1:0] ST_DRAIN  = CFG_DRAIN;
  localparam logic [1:0] ST_SETTLE = CFG_SETTLE;

  // Settle counter counts SETTLE_CYC-1 down to 0; keep at least one bit.
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] pend_q, pend_d;
  logic [SC_W-1:0] settle_q, settle_d;
  logic            bad_id_q, bad_id_d;
  logic            proto_err_q, proto_err_d;

  logic [CNT_W-1:0] inflight;
  logic             cnt_err;
  logic             accept;
  logic             id_legal;
  logic             cfg_valid;

  cfg_inflight_cnt #(
    .CNT_W (CNT_W)
  ) u_inflight_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (in_fire_i),
    .dec_i  (out_fire_i),
    .cnt_o  (inflight),
    .err_o  (cnt_err)
  );

  // Requests are only taken while nothing is being reconfigured; they are
  // never queued, the master simply holds valid until ready returns.
  assign req.ready = (state_q == ST_UNCFG) || (state_q == ST_ACTIVE);
  assign accept    = req.valid && req.ready;
  assign id_legal  = (req.id != '0) && (32'(req.id) <= NUM_CFG);
  assign cfg_valid = (state_q == ST_ACTIVE);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    pend_d      = pend_q;
    settle_d    = settle_q;
    bad_id_d    = 1'b0;
    // Tokens entering an unconfigured network are still counted, but flagged.
    proto_err_d = proto_err_q | cnt_err | (in_fire_i & ~cfg_valid);

    unique case (state_q)
      ST_UNCFG, ST_ACTIVE: begin
        if (accept) begin
          if (!id_legal) begin
            bad_id_d = 1'b1;
          end else if (!((state_q == ST_ACTIVE) && (req.id == id_q))) begin
            // Re-requesting the active ID completes the handshake only.
            pend_d  = req.id;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Switch on the first cycle the registered count shows an empty
        // network; the new ID appears together with the SETTLE state.
        if (inflight == '0) begin
          id_d     = pend_q;
          settle_d = SC_W'(SETTLE_CYC - 1);
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d  = ST_ACTIVE;
        else                settle_d = settle_q - SC_W'(1);
      end
      default: state_d = ST_UNCFG;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_UNCFG;
      id_q        <= '0;
      pend_q      <= '0;
      settle_q    <= '0;
      bad_id_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      pend_q      <= pend_d;
      settle_q    <= settle_d;
      bad_id_q    <= bad_id_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign id_o        = id_q;
  assign cfg_valid_o = cfg_valid;
  assign busy_o      = (state_q == ST_DRAIN) || (state_q == ST_SETTLE);
  assign inflight_o  = inflight;
  assign bad_id_o    = bad_id_q;
  assign proto_err_o = proto_err_q;

endmodule : cfg_switch_ctrl

// File: tb/tb_cfg_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cfg_switch_ctrl
// Directed scenarios plus a randomized run of cfg_switch_ctrl, compared every
// cycle against a behavioural model of the sequencer.
// -----------------------------------------------------------------------------
module tb_cfg_switch_ctrl;
  import cfg_switch_ctrl_pkg::*;

  localparam int CNT_MAX = (1 << CFG_CNT_W) - 1;

  logic                 clk      = 1'b0;
  logic                 rst_n    = 1'b1;
  logic                 in_fire  = 1'b0;
  logic                 out_fire = 1'b0;
  logic [CFG_ID_W-1:0]  id_o;
  logic                 cfg_valid_o, busy_o, bad_id_o, proto_err_o;
  logic [CFG_CNT_W-1:0] inflight_o;
  bit                   started  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  cfg_switch_ctrl_if req_if ();

  cfg_switch_ctrl #(
    .ID_W       (CFG_ID_W),
    .NUM_CFG    (CFG_NUM_CFG),
    .CNT_W      (CFG_CNT_W),
    .SETTLE_CYC (CFG_SETTLE_CYC)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req         (req_if.slave),
    .in_fire_i   (in_fire),
    .out_fire_i  (out_fire),
    .id_o        (id_o),
    .cfg_valid_o (cfg_valid_o),
    .busy_o      (busy_o),
    .inflight_o  (inflight_o),
    .bad_id_o    (bad_id_o),
    .proto_err_o (proto_err_o)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model: mode, current/pending ID, token count, remaining settle
  // cycles (including the current one), pulse and sticky error.
  // ---------------------------------------------------------------------------
  typedef enum int {M_UNCFG, M_ACTIVE, M_DRAIN, M_SETTLE} mode_t;
  mode_t m_mode = M_UNCFG;
  int    m_id   = 0;
  int    m_pend = 0;
  int    m_cnt  = 0;
  int    m_left = 0;
  bit    m_bad  = 1'b0;
  bit    m_err  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit fire;
    int rid;
    int cnt_before;
    if (!rst_n) begin
      m_mode = M_UNCFG;
      m_id   = 0;
      m_pend = 0;
      m_cnt  = 0;
      m_left = 0;
      m_bad  = 1'b0;
      m_err  = 1'b0;
    end else begin
      fire       = req_if.valid && (m_mode == M_UNCFG || m_mode == M_ACTIVE);
      rid        = int'(req_if.id);
      cnt_before = m_cnt;
      m_bad      = fire && (rid < 1 || rid > CFG_NUM_CFG);
      if (in_fire && !out_fire) begin
        if (m_cnt == CNT_MAX) m_err = 1'b1;
        else                  m_cnt = m_cnt + 1;
      end else if (out_fire && !in_fire) begin
        if (m_cnt == 0) m_err = 1'b1;
        else            m_cnt = m_cnt - 1;
      end
      if (in_fire && m_mode != M_ACTIVE) m_err = 1'b1;
      case (m_mode)
        M_UNCFG, M_ACTIVE: begin
          if (fire && !m_bad && !(m_mode == M_ACTIVE && rid == m_id)) begin
            m_pend = rid;
            m_mode = M_DRAIN;
          end
        end
        M_DRAIN: begin
          if (cnt_before == 0) begin
            m_id   = m_pend;
            m_left = CFG_SETTLE_CYC;
            m_mode = M_SETTLE;
          end
        end
        M_SETTLE: begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_ACTIVE;
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("ready",     32'(req_if.ready), 32'(m_mode == M_UNCFG || m_mode == M_ACTIVE));
      check("id",        32'(id_o),         m_id);
      check("cfg_valid", 32'(cfg_valid_o),  32'(m_mode == M_ACTIVE));
      check("busy",      32'(busy_o),       32'(m_mode == M_DRAIN || m_mode == M_SETTLE));
      check("inflight",  32'(inflight_o),   m_cnt);
      check("bad_id",    32'(bad_id_o),     32'(m_bad));
      check("proto_err", 32'(proto_err_o),  32'(m_err));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 started = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic request(input int id);
    req_if.id    = CFG_ID_W'(id);
    req_if.valid = 1'b1;
    tick();
    req_if.valid = 1'b0;
  endtask

  task automatic wait_active(input int budget);
    int n = 0;
    while (!cfg_valid_o && n < budget) begin
      tick();
      n++;
    end
    check("wait_active_timeout", 32'(cfg_valid_o), 1);
  endtask

  int bad_ids[2] = '{0, 7};

  initial begin
    req_if.valid = 1'b0;
    req_if.id    = '0;

    // --- 1: reset values, then ID=2 with an empty network -------------------
    do_reset();
    check("rst_id",        32'(id_o),         0);
    check("rst_cfg_valid", 32'(cfg_valid_o),  0);
    check("rst_ready",     32'(req_if.ready), 1);
    request(2);                                           // now T+1
    check("t1_busy",      32'(busy_o),      1);
    check("t1_cfg_valid", 32'(cfg_valid_o), 0);
    check("t1_id",        32'(id_o),        0);
    tick();                                               // T+2
    check("t2_id",   32'(id_o),   2);
    check("t2_busy", 32'(busy_o), 1);
    tick();                                               // T+3
    check("t3_cfg_valid", 32'(cfg_valid_o), 0);
    tick();                                               // T+4
    check("t4_cfg_valid", 32'(cfg_valid_o), 1);
    check("t4_busy",      32'(busy_o),      0);

    // --- 2: drain 5 tokens before switching 1 -> 3 --------------------------
    request(1);
    wait_active(20);
    check("act1_id", 32'(id_o), 1);
    in_fire = 1'b1;
    repeat (5) tick();
    in_fire = 1'b0;
    check("push5_inflight", 32'(inflight_o), 5);
    request(3);
    check("drain_busy", 32'(busy_o), 1);
    for (int k = 0; k < 5; k++) begin
      out_fire = 1'b1;
      tick();
      out_fire = 1'b0;
      check("drain_inflight", 32'(inflight_o), 4 - k);
      check("drain_id_held",  32'(id_o),       1);
      if (k < 4) repeat (2) tick();
    end
    tick();
    check("switch_id",        32'(id_o),        3);
    check("switch_cfg_valid", 32'(cfg_valid_o), 0);
    repeat (CFG_SETTLE_CYC - 1) tick();
    check("settle_cfg_valid", 32'(cfg_valid_o), 0);
    tick();
    check("resume_cfg_valid", 32'(cfg_valid_o), 1);

    // --- 3: illegal IDs pulse bad_id_o and change nothing -------------------
    foreach (bad_ids[i]) begin
      request(bad_ids[i]);
      check("bad_pulse",     32'(bad_id_o),    1);
      check("bad_id_kept",   32'(id_o),        3);
      check("bad_cfg_valid", 32'(cfg_valid_o), 1);
      tick();
      check("bad_pulse_end", 32'(bad_id_o),    0);
      check("bad_busy",      32'(busy_o),      0);
    end

    // --- 4: re-requesting the active ID is a no-op --------------------------
    check("noop_ready", 32'(req_if.ready), 1);
    request(3);
    check("noop_cfg_valid", 32'(cfg_valid_o), 1);
    check("noop_busy",      32'(busy_o),      0);
    repeat (3) begin
      tick();
      check("noop_hold", 32'(cfg_valid_o), 1);
    end

    // --- 5: request held during DRAIN waits for ACTIVE ----------------------
    in_fire = 1'b1;
    repeat (2) tick();
    in_fire = 1'b0;
    request(1);
    req_if.id    = CFG_ID_W'(2);
    req_if.valid = 1'b1;
    check("drain_not_ready", 32'(req_if.ready), 0);
    out_fire = 1'b1;
    repeat (2) begin
      tick();
      check("drain_not_ready", 32'(req_if.ready), 0);
    end
    out_fire = 1'b0;
    begin
      int n = 0;
      while (!req_if.ready && n < 20) begin
        tick();
        n++;
      end
    end
    check("ready_timeout",   32'(req_if.ready), 1);
    check("ready_active_id", 32'(id_o),         1);
    tick();
    req_if.valid = 1'b0;
    check("held_req_accepted", 32'(busy_o), 1);
    wait_active(20);
    check("held_req_id", 32'(id_o), 2);

    // Underflow: counter stays 0, error sticks.
    check("pre_uf_err", 32'(proto_err_o), 0);
    out_fire = 1'b1;
    tick();
    out_fire = 1'b0;
    check("uf_inflight", 32'(inflight_o),  0);
    check("uf_err",      32'(proto_err_o), 1);
    repeat (3) tick();
    check("uf_err_sticky", 32'(proto_err_o), 1);

    // --- 6: overflow saturates at the maximum count -------------------------
    do_reset();
    request(1);
    wait_active(20);
    check("pre_of_err", 32'(proto_err_o), 0);
    in_fire = 1'b1;
    repeat (CNT_MAX) tick();
    check("full_inflight", 32'(inflight_o),  CNT_MAX);
    check("full_no_err",   32'(proto_err_o), 0);
    tick();
    in_fire = 1'b0;
    check("of_inflight", 32'(inflight_o),  CNT_MAX);
    check("of_err",      32'(proto_err_o), 1);

    // --- 7: reset in the middle of SETTLE -----------------------------------
    do_reset();
    request(2);
    tick();
    check("in_settle_busy", 32'(busy_o), 1);
    check("in_settle_id",   32'(id_o),   2);
    #1 rst_n = 1'b0;
    #1;
    check("arst_id",        32'(id_o),         0);
    check("arst_busy",      32'(busy_o),       0);
    check("arst_cfg_valid", 32'(cfg_valid_o),  0);
    check("arst_ready",     32'(req_if.ready), 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_cfg_valid", 32'(cfg_valid_o), 0);

    // --- 8: randomized traffic and requests ---------------------------------
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      req_if.valid = ($urandom_range(0, 3) == 0);
      req_if.id    = CFG_ID_W'($urandom_range(0, 4));
      in_fire      = (m_mode == M_ACTIVE) ? 1'($urandom_range(0, 1))
                                          : ($urandom_range(0, 39) == 0);
      out_fire     = (m_cnt > 0) ? 1'($urandom_range(0, 1))
                                 : ($urandom_range(0, 59) == 0);
      tick();
    end
    req_if.valid = 1'b0;
    in_fire      = 1'b0;
    out_fire     = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cfg_switch_ctrl

// File: doc/cfg_switch_ctrl.md
Name: cfg_switch_ctrl

Overview:
- Upstream sequencer for the kernel configurator. Accepts dataflow-configuration ID requests from the HWPE control slave over a valid/ready handshake and drives the 8-bit ID into the configurator.
- Guarantees an ID change only when the reconfigurable network holds no in-flight tokens. Holds the change through a settle window, then re-enables streaming into the network.

Parameters:
- ID_W, 8, width of configuration ID (matches configurator input)
- NUM_CFG, 3, valid IDs are 1..NUM_CFG; 0 and >NUM_CFG rejected
- CNT_W, 8, width of in-flight token counter
- SETTLE_CYC, 2, cycles ID_o is held stable before streaming resumes; must be >=1

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  new configuration request valid
- req_id_i  in  ID_W  requested configuration ID
- req_ready_o  out  1  request accepted when valid&ready
- in_fire_i  in  1  token entered network this cycle
- out_fire_i  in  1  token left network this cycle
- id_o  out  ID_W  ID driven to configurator
- cfg_valid_o  out  1  network configured; input streamer may fire
- busy_o  out  1  reconfiguration in progress (DRAIN or SETTLE)
- inflight_o  out  CNT_W  current in-flight token count
- bad_id_o  out  1  one-cycle pulse: accepted request had an illegal ID
- proto_err_o  out  1  sticky: counter over/underflow, or in_fire_i while cfg_valid_o=0

Behaviour:
- Reset (async assert, sync release): state UNCFG; id_o=0, cfg_valid_o=0, busy_o=0, inflight_o=0, bad_id_o=0, proto_err_o=0; pending ID register=0. Reset mid-reconfiguration abandons it and returns to UNCFG.
- States: UNCFG, ACTIVE, DRAIN, SETTLE.
- req_ready_o=1 in UNCFG and ACTIVE; 0 in DRAIN and SETTLE. Requests are never queued.
- Accept at cycle T with illegal ID (0 or >NUM_CFG): bad_id_o=1 at T+1 for one cycle; state, id_o and cfg_valid_o unchanged.
- Accept in ACTIVE with req_id_i==id_o: no-op; handshake completes, no state change.
- Any other legal accept: latch pending ID.
  - T+1: state DRAIN; cfg_valid_o=0; busy_o=1.
- DRAIN exit: in the first DRAIN cycle with inflight_o==0, id_o<=pending.
  - Next cycle: state SETTLE; settle counter loaded with SETTLE_CYC-1.
- SETTLE: lasts exactly SETTLE_CYC cycles. The following cycle is ACTIVE, with cfg_valid_o=1 and busy_o=0.
- Minimum latency with an empty network (SETTLE_CYC=2): accept at T; id_o new at T+2; cfg_valid_o=1 at T+4.
- In-flight counter, per cycle:
  - +1 on in_fire_i only; -1 on out_fire_i only; unchanged when both or neither.
  - Saturates at 2^CNT_W-1; set proto_err_o on an attempted overflow.
  - Holds 0 on underflow (out_fire_i at 0); set proto_err_o.
  - Counts in every state, including DRAIN.
- in_fire_i while cfg_valid_o=0: still counted; sets proto_err_o.
- proto_err_o cleared only by reset.

Decomposition:
- Shared package: state enum (UNCFG/ACTIVE/DRAIN/SETTLE), ID_W, NUM_CFG, and named ID constants (1, 2, 3) common with the configurator.
- One natural sub-module: cfg_inflight_cnt, the saturating up/down counter plus over/underflow flag. FSM and handshake stay in the top level.

Test Plan:
- Reset, then request ID=2 with no traffic -> id_o=2 two cycles after accept; cfg_valid_o=1 four cycles after accept; busy_o high in between.
- Reach ACTIVE ID=1; push 5 tokens, request ID=3, then drain one token every 3 cycles -> id_o stays 1 until inflight_o reaches 0; id_o=3 the cycle after zero is observed; cfg_valid_o=1 SETTLE_CYC cycles later.
- Request ID=0, then ID=7 -> each produces a one-cycle bad_id_o pulse; id_o and state unchanged.
- Request ID=1 while ACTIVE with id_o=1 -> accepted in one cycle; cfg_valid_o never drops.
- Assert req_valid_i during DRAIN -> req_ready_o=0 until ACTIVE, then accepted. Separately, out_fire_i with inflight_o=0 -> counter stays 0, proto_err_o=1 and sticky.
- Assert rst_ni low during SETTLE -> outputs return immediately to reset values, state UNCFG.
